// File: rtl/or1200_decryption_fsm_pkg.sv
// Shared definitions for the load-side decryption block: FSM state
// encodings, block geometry and the AES-128 arithmetic helpers used by the
// inverse cipher core.
package or1200_decryption_fsm_pkg;

  localparam int OR1200_DEC_WORDS = 4;
  localparam logic [1:0] LAST_IDX = 2'(OR1200_DEC_WORDS - 1);
  localparam logic [3:0] AES_ROUNDS = 4'd10;

  typedef enum logic [2:0] {
    NOKEY   = 3'd0,
    KEXP    = 3'd1,
    COLLECT = 3'd2,
    DECRYPT = 3'd3,
    DRAIN   = 3'd4
  } dec_state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  // Forward S-box: inverse followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = ginv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^
           {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine transform followed by the field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] y;
    y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // One step of the forward key schedule (round key i-1 -> i).
  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // One step of the key schedule run backwards (round key i -> i-1).
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  // State bytes are column-major with byte 0 in the top bits.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8 * i +: 8] = inv_sbox(s[8 * i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/or1200_decryption_fsm_aes_inv_cipher_top.sv
// Iterative AES-128 inverse cipher, one round per clock.
// kld expands the key forward over 10 clocks and keeps the last round key;
// decryption then walks the schedule backwards alongside the rounds, so no
// round-key storage is needed. done pulses for one cycle with text_out valid.
// rst is active-low.
module aes_inv_cipher_top
  import or1200_decryption_fsm_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic         ld,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic [127:0] text_out,
  output logic         done
);

  logic [127:0] last_key;
  logic [3:0]   kcnt;
  logic [127:0] round_key;
  logic [127:0] st;
  logic [3:0]   rnd;
  logic         busy;
  logic [127:0] prev_key;
  logic [127:0] round_out;

  // Round datapath: previous round key and the shared round body.
  always_comb begin
    prev_key  = key_inv(round_key, rcon(rnd));
    round_out = inv_sub_bytes(inv_shift_rows(st)) ^ prev_key;
  end

  // Forward key expansion; kld restarts it even mid-run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_key <= '0;
      kcnt     <= 4'd0;
    end else if (kld) begin
      last_key <= key_fwd(key, rcon(4'd1));
      kcnt     <= 4'd1;
    end else if (kcnt != 4'd0 && kcnt != AES_ROUNDS) begin
      last_key <= key_fwd(last_key, rcon(kcnt + 4'd1));
      kcnt     <= kcnt + 4'd1;
    end
  end

  // Round sequencer; a new kld cancels any block in flight so no done follows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= '0;
      round_key <= '0;
      rnd       <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kld) begin
        busy <= 1'b0;
      end else if (ld) begin
        st        <= text_in ^ last_key;
        round_key <= last_key;
        rnd       <= AES_ROUNDS;
        busy      <= 1'b1;
      end else if (busy) begin
        round_key <= prev_key;
        rnd       <= rnd - 4'd1;
        if (rnd == 4'd1) begin
          st   <= round_out;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          st <= inv_mix_columns(round_out);
        end
      end
    end
  end

  assign text_out = st;

endmodule

// File: rtl/or1200_decryption_fsm.sv
// Load-side decryption FSM: gathers four ciphertext words from the cache,
// runs them through the AES-128 inverse cipher and hands four plaintext
// words to the LSU, holding the LSU stalled while a block is in progress.
// Optional feature macro: OR1200_DECRYPTION_BYPASS_EN adds dec_bypass, which
// passes words straight through when set at the start of a block.
//
// Handshake rule for both cin_* and pout_*: a word moves only on a rising
// clock edge where valid and ready are both high; valid never waits on ready,
// and pout_data holds while pout_valid is high and pout_ready is low.
module or1200_decryption_fsm
  import or1200_decryption_fsm_pkg::*;
#(
  parameter int KEXP_CYCLES = 10,
  parameter int CNT_W       = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] dec_key,
  input  logic         key_load,
`ifdef OR1200_DECRYPTION_BYPASS_EN
  input  logic         dec_bypass,
`endif
  input  logic [31:0]  cin_data,
  input  logic         cin_valid,
  output logic         cin_ready,
  output logic [31:0]  pout_data,
  output logic         pout_valid,
  input  logic         pout_ready,
  output logic         unstall,
  output logic         key_ok,
  output dec_state_t   state_dbg
);

  localparam logic [CNT_W-1:0] KEXP_LAST = CNT_W'(KEXP_CYCLES - 1);

  dec_state_t       state;
  dec_state_t       next_state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] kcnt;
  logic [127:0]     key_r;
  logic [127:0]     cin_buf;
  logic [127:0]     pt_buf;
  logic             kld;
  logic             ld;
  logic             core_done;
  logic [127:0]     core_text;
  logic             byp;
  logic             store;
  logic             pout_fire;

  aes_inv_cipher_top u_aes (
    .clk      (clk),
    .rst      (!rst),
    .kld      (kld),
    .ld       (ld),
    .key      (key_r),
    .text_in  (cin_buf),
    .text_out (core_text),
    .done     (core_done)
  );

  // Next-state and handshake outputs; key_load overrides everything.
  always_comb begin
    next_state = state;
    cin_ready  = 1'b0;
    pout_valid = 1'b0;
    pout_data  = pt_buf[32 * idx +: 32];
    unstall    = 1'b0;
    byp        = 1'b0;
    case (state)
      NOKEY: unstall = 1'b1;
      KEXP: begin
        if (kcnt == KEXP_LAST) next_state = COLLECT;
      end
      COLLECT: begin
        cin_ready = 1'b1;
        unstall   = (idx == 2'd0);
`ifdef OR1200_DECRYPTION_BYPASS_EN
        if (idx == 2'd0 && dec_bypass) begin
          byp        = 1'b1;
          cin_ready  = pout_ready;
          pout_valid = cin_valid;
          pout_data  = cin_data;
          unstall    = 1'b1;
        end
`endif
        if (cin_valid && cin_ready && !byp && idx == LAST_IDX) next_state = DECRYPT;
      end
      DECRYPT: begin
        if (core_done) next_state = DRAIN;
      end
      DRAIN: begin
        pout_valid = 1'b1;
        if (pout_ready && idx == LAST_IDX) begin
          unstall    = 1'b1;
          next_state = COLLECT;
        end
      end
      default: next_state = NOKEY;
    endcase
    if (key_load) begin
      next_state = KEXP;
      cin_ready  = 1'b0;
      pout_valid = 1'b0;
    end
    store     = (state == COLLECT) && cin_valid && cin_ready && !byp;
    pout_fire = (state == DRAIN) && pout_valid && pout_ready;
  end

  // State register, word index, buffers and the kld/ld entry pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= NOKEY;
      idx     <= 2'd0;
      kcnt    <= '0;
      key_r   <= '0;
      cin_buf <= '0;
      pt_buf  <= '0;
      key_ok  <= 1'b0;
      kld     <= 1'b0;
      ld      <= 1'b0;
    end else begin
      state <= next_state;
      kld   <= 1'b0;
      ld    <= 1'b0;
      if (key_load) begin
        // Abort: drop partial ciphertext and any undelivered plaintext.
        key_r   <= dec_key;
        key_ok  <= 1'b0;
        kld     <= 1'b1;
        kcnt    <= '0;
        idx     <= 2'd0;
        cin_buf <= '0;
        pt_buf  <= '0;
      end else begin
        case (state)
          KEXP: begin
            if (kcnt == KEXP_LAST) begin
              key_ok <= 1'b1;
              kcnt   <= '0;
            end else begin
              kcnt <= kcnt + 1'b1;
            end
          end
          COLLECT: begin
            if (store) begin
              cin_buf[32 * idx +: 32] <= cin_data;
              // idx only returns to 0 together with the move to DECRYPT.
              if (idx == LAST_IDX) begin
                idx <= 2'd0;
                ld  <= 1'b1;
              end else begin
                idx <= idx + 2'd1;
              end
            end
          end
          DECRYPT: begin
            if (core_done) pt_buf <= core_text;
          end
          DRAIN: begin
            if (pout_fire) idx <= (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_or1200_decryption_fsm.sv
// Directed bench for or1200_decryption_fsm using FIPS-197 AES-128 vectors.
module tb_or1200_decryption_fsm;
  import or1200_decryption_fsm_pkg::*;

  logic         clk;
  logic         rst;
  logic [127:0] dec_key;
  logic         key_load;
  logic [31:0]  cin_data;
  logic         cin_valid;
  logic         cin_ready;
  logic [31:0]  pout_data;
  logic         pout_valid;
  logic         pout_ready;
  logic         unstall;
  logic         key_ok;
  dec_state_t   state_dbg;
`ifdef OR1200_DECRYPTION_BYPASS_EN
  logic         dec_bypass;
`endif

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  logic [31:0] exp_q[$];

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  or1200_decryption_fsm u_dut (
    .clk        (clk),
    .rst        (rst),
    .dec_key    (dec_key),
    .key_load   (key_load),
`ifdef OR1200_DECRYPTION_BYPASS_EN
    .dec_bypass (dec_bypass),
`endif
    .cin_data   (cin_data),
    .cin_valid  (cin_valid),
    .cin_ready  (cin_ready),
    .pout_data  (pout_data),
    .pout_valid (pout_valid),
    .pout_ready (pout_ready),
    .unstall    (unstall),
    .key_ok     (key_ok),
    .state_dbg  (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted plaintext word is compared to the queue head.
  always @(negedge clk) begin
    if (!rst && pout_valid && pout_ready) begin
      if (exp_q.size() == 0) begin
        check("stale_output", 128'(pout_valid), 128'd0);
      end else begin
        check("pout_data", 128'(pout_data), 128'(exp_q.pop_front()));
        out_cnt++;
      end
    end
  end

  // Driver tasks
  task automatic send_word(input logic [31:0] w, input bit keep_valid);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    cin_data = w;
    cin_valid = 1'b1;
    while (!ok && n < 400) begin
      @(negedge clk);
      ok = cin_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!keep_valid) cin_valid = 1'b0;
    check("cin_accept", 128'(ok), 128'd1);
  endtask

  task automatic send_block(input logic [127:0] ct, input logic [127:0] pt, input bit hold);
    for (int i = 0; i < 4; i++) exp_q.push_back(pt[32 * i +: 32]);
    for (int i = 0; i < 4; i++) send_word(ct[32 * i +: 32], hold);
  endtask

  task automatic wait_key_ok();
    int n;
    n = 0;
    while (!key_ok && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("key_ok_latency", 128'(n), 128'd10);
  endtask

  task automatic load_key(input logic [127:0] k);
    @(posedge clk);
    #1;
    dec_key = k;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    dec_key = '0;
    check("kexp_state", 128'(state_dbg), 128'(KEXP));
    check("kexp_unstall", 128'(unstall), 128'd0);
    wait_key_ok();
    check("collect_state", 128'(state_dbg), 128'(COLLECT));
    check("collect_cin_ready", 128'(cin_ready), 128'd1);
    check("collect_unstall", 128'(unstall), 128'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pout_valid && n < 100);
    check("pout_valid_wait", 128'(pout_valid), 128'd1);
  endtask

  // Directed sequence
  initial begin
    logic [127:0] ct_v;
    logic [127:0] pt_v;
    int base;
    rst = 1'b1;
    dec_key = '0;
    key_load = 1'b0;
    cin_data = '0;
    cin_valid = 1'b0;
    pout_ready = 1'b1;
`ifdef OR1200_DECRYPTION_BYPASS_EN
    dec_bypass = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 128'(state_dbg), 128'(NOKEY));
    check("rst_key_ok", 128'(key_ok), 128'd0);
    check("rst_cin_ready", 128'(cin_ready), 128'd0);
    check("rst_pout_valid", 128'(pout_valid), 128'd0);
    check("rst_pout_data", 128'(pout_data), 128'd0);
    check("rst_unstall", 128'(unstall), 128'd1);
    rst = 1'b0;

    // FIPS-197 C.1 block, LSU always ready
    load_key(KEY_C1);
    send_block(CT_C1, PT_C1, 1'b0);
    check("decrypt_state", 128'(state_dbg), 128'(DECRYPT));
    check("decrypt_unstall", 128'(unstall), 128'd0);
    check("decrypt_cin_ready", 128'(cin_ready), 128'd0);
    wait_drain();

    // Backpressure on word 1, then on word 3
    pout_ready = 1'b0;
    send_block(CT_C1, PT_C1, 1'b0);
    wait_valid();
    check("bp_word0", 128'(pout_data), 128'h00000000_00000000_00000000_ccddeeff);
    @(posedge clk); #1; pout_ready = 1'b1;
    @(posedge clk); #1; pout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 128'(pout_valid), 128'd1);
      check("bp_hold_data", 128'(pout_data), 128'h8899aabb);
    end
    @(posedge clk); #1; pout_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; pout_ready = 1'b0;
    @(negedge clk);
    check("bp_word3_data", 128'(pout_data), 128'h00112233);
    check("bp_word3_stall", 128'(unstall), 128'd0);
    @(posedge clk); #1; pout_ready = 1'b1;
    @(negedge clk);
    check("bp_word3_unstall", 128'(unstall), 128'd1);
    wait_drain();
    check("bp_back_collect", 128'(state_dbg), 128'(COLLECT));
    check("bp_no_valid", 128'(pout_valid), 128'd0);

    // Abort after two words; key_load coincides with a third offered word
    ct_v = CT_C1;
    send_word(ct_v[31:0], 1'b0);
    send_word(ct_v[63:32], 1'b0);
    cin_data = 32'hdeadbeef;
    cin_valid = 1'b1;
    dec_key = KEY_B;
    key_load = 1'b1;
    @(negedge clk);
    check("abort_cin_ready", 128'(cin_ready), 128'd0);
    @(posedge clk); #1;
    key_load = 1'b0;
    cin_valid = 1'b0;
    dec_key = '0;
    check("abort_state", 128'(state_dbg), 128'(KEXP));
    check("abort_key_ok", 128'(key_ok), 128'd0);
    wait_key_ok();
    send_block(CT_B, PT_B, 1'b0);
    wait_drain();

    // Abort mid-DECRYPT: the late core result must never appear
    ct_v = CT_C1;
    for (int i = 0; i < 4; i++) send_word(ct_v[32 * i +: 32], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    load_key(KEY_B);
    repeat (20) @(posedge clk);
    #1;
    check("abort_dec_no_valid", 128'(pout_valid), 128'd0);
    send_block(CT_B, PT_B, 1'b0);
    wait_drain();

    // Back-to-back blocks with cin_valid held high
    base = out_cnt;
    send_block(CT_B, PT_B, 1'b1);
    ct_v = CT_B;
    pt_v = PT_B;
    for (int i = 0; i < 4; i++) exp_q.push_back(pt_v[32 * i +: 32]);
    send_word(ct_v[31:0], 1'b1);
    check("b2b_first_drained", 128'(out_cnt - base), 128'd4);
    for (int i = 1; i < 4; i++) send_word(ct_v[32 * i +: 32], i != 3);
    wait_drain();

`ifdef OR1200_DECRYPTION_BYPASS_EN
    // Bypass: word goes straight through in the same cycle
    dec_bypass = 1'b1;
    exp_q.push_back(32'h12345678);
    cin_data = 32'h12345678;
    cin_valid = 1'b1;
    @(negedge clk);
    check("byp_valid", 128'(pout_valid), 128'd1);
    check("byp_data", 128'(pout_data), 128'h12345678);
    check("byp_cin_ready", 128'(cin_ready), 128'd1);
    @(posedge clk); #1;
    cin_valid = 1'b0;
    dec_bypass = 1'b0;
    check("byp_state", 128'(state_dbg), 128'(COLLECT));
    check("byp_drained", 128'(exp_q.size()), 128'd0);
`endif

    // Reset in the middle of DRAIN
    pout_ready = 1'b0;
    send_block(CT_B, PT_B, 1'b0);
    wait_valid();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 128'(pout_valid), 128'd0);
    check("mid_rst_unstall", 128'(unstall), 128'd1);
    check("mid_rst_key_ok", 128'(key_ok), 128'd0);
    check("mid_rst_state", 128'(state_dbg), 128'(NOKEY));
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    pout_ready = 1'b1;
    cin_valid = 1'b1;
    cin_data = 32'h0badf00d;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_cin_ready", 128'(cin_ready), 128'd0);
    end
    @(posedge clk); #1;
    cin_valid = 1'b0;
    check("post_rst_pout_data", 128'(pout_data), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
